plot_frame_receiver: RTL and testbench
======================================

// Module: plot_frame_receiver
// PURPOSE
//  Receive side of the renderer's pixel plot stream (x, y, color, plot).
//  Converts each plotted pixel to a linear framebuffer address and buffers it in a small FIFO.
//  Drains the FIFO into framebuffer RAM through a ready/valid write port.
//  Checks raster order and frame completion, so the renderer can be verified and frame rate measured.
// PARAMETERS
//  X_MAX       159  last valid column (inclusive)
//  Y_MAX       119  last valid row (inclusive)
//  COLOR_W     3    colour width
//  ADDR_W      15   framebuffer address width; must hold (X_MAX+1)*(Y_MAX+1)-1
//  FIFO_DEPTH  4    entries; power of two, >=2
// PORTS
//  clk          in   1        system clock
//  reset        in   1        synchronous, active-high
//  x            in   8        pixel column
//  y            in   8        pixel row
//  color        in   COLOR_W  pixel colour
//  plot         in   1        pixel valid strobe; one pixel per high cycle
//  in_ready     out  1        = !fifo_full && !reset (combinational)
//  fb_addr      out  ADDR_W   write address = y*(X_MAX+1)+x
//  fb_data      out  COLOR_W  write data
//  fb_we        out  1        write valid; high whenever FIFO non-empty
//  fb_ready     in   1        RAM accepts the write this cycle
//  frame_done   out  1        1-cycle pulse after the last pixel of a frame is accepted
//  frame_cnt    out  8        completed frames, wraps 255->0
//  order_err    out  1        sticky: an accepted pixel was not at the expected raster position
//  range_err    out  1        sticky: plot seen with x>X_MAX or y>Y_MAX
//  drop_cnt     out  8        plot strobes lost while FIFO full; saturates at 255
// BEHAVIOUR
//  Reset: FIFO empty, fb_we=0, fb_addr=0, fb_data=0, frame_done=0, frame_cnt=0.
//   Reset also clears order_err=0, range_err=0 and drop_cnt=0, and sets expected (ex,ey)=(0,0).
//   Reset mid-stream discards FIFO contents; fb_we=0 on the cycle after reset is sampled.
//  Accept: plot && in_ready && in range.
//   Push {addr,color}; addr computed as (y*(X_MAX+1))+x at ADDR_W bits, with no truncation allowed.
//  Out of range: no push, range_err<=1, expected position and counters unchanged.
//  Full: plot && !in_ready -> no push, drop_cnt+1 (saturating), expected position unchanged.
//  Order check on each accept:
//   - (x,y)!=(ex,ey) sets order_err.
//   - In all cases, expected resyncs to the successor of (x,y): x<X_MAX -> (x+1,y).
//   - Otherwise (0,y+1); if y==Y_MAX -> (0,0).
//  Frame end: accepting (X_MAX,Y_MAX) -> frame_done=1 next cycle and frame_cnt+1 the same cycle.
//   This applies even if order_err is set.
//  FIFO: show-ahead; fb_addr/fb_data always present the head entry.
//   Pop when fb_we && fb_ready.
//   Push and pop in the same cycle: occupancy unchanged. This is legal when full, but in_ready is still 0 when full, so no push occurs.
//  Latency: pixel accepted in cycle N drives fb_we earliest in cycle N+1.
//   With fb_ready=1 held, sustained throughput is 1 pixel/cycle.
//  fb_we/fb_addr/fb_data hold stable while fb_ready=0.
//  Ordering: writes leave in exactly accept order; no coalescing of repeated addresses.
//  Renderer plots at most every other cycle, so with fb_ready=1 no drops occur.
// TESTING
//  T1 reset, then one plot x=0,y=0,color=5 -> next cycle fb_we=1, fb_addr=0, fb_data=5.
//     Pop with fb_ready=1; then fb_we=0 and order_err=0.
//  T2 full raster 160x120 in order, fb_ready=1 -> 19200 writes.
//     Last write has fb_addr=19199; frame_done pulses once; frame_cnt=1; order_err=0.
//  T3 fb_ready=0, plot 6 pixels back-to-back -> 4 buffered, in_ready=0, drop_cnt=2.
//     Then release fb_ready -> 4 writes in order.
//  T4 plot (0,0),(5,0) -> order_err=1 on the second.
//     Next plot (6,0) raises no further error; order_err stays 1 until reset.
//  T5 plot x=160,y=3 -> range_err=1, no fb_we; plot y=120 also rejected.
//  T6 reset asserted with 3 entries queued -> FIFO empty, fb_we=0, counters/flags 0.
//     Next plot (0,0) accepted normally.

Source files
------------

// File: rtl/plot_frame_receiver.sv
// Receive side of the renderer pixel stream: maps (x,y) to a linear framebuffer
// address, buffers writes in a show-ahead FIFO and checks raster order / frame end.
module plot_frame_receiver #(
   parameter int X_MAX      = 159,
   parameter int Y_MAX      = 119,
   parameter int COLOR_W    = 3,
   parameter int ADDR_W     = 15,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         x,
   input  logic [7:0]         y,
   input  logic [COLOR_W-1:0] color,
   input  logic               plot,
   output logic               in_ready,
   output logic [ADDR_W-1:0]  fb_addr,
   output logic [COLOR_W-1:0] fb_data,
   output logic               fb_we,
   input  logic               fb_ready,
   output logic               frame_done,
   output logic [7:0]         frame_cnt,
   output logic               order_err,
   output logic               range_err,
   output logic [7:0]         drop_cnt
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int ENTRY_W = ADDR_W + COLOR_W;
   localparam logic [7:0] X_LAST = 8'(X_MAX);
   localparam logic [7:0] Y_LAST = 8'(Y_MAX);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

   logic [ENTRY_W-1:0] fifoMem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wrPtr;
   logic [PTR_W-1:0]   rdPtr;
   logic [PTR_W:0]     fillCount;
   logic               fifoFull;
   logic               fifoEmpty;
   logic               inRange;
   logic               accept;
   logic               pop;
   logic               lastPixel;
   logic [ADDR_W-1:0]  pixAddr;
   logic [ENTRY_W-1:0] headEntry;
   logic [7:0]         expX;
   logic [7:0]         expY;
   logic [7:0]         nextX;
   logic [7:0]         nextY;

   assign fifoFull  = (fillCount == FULL_COUNT);
   assign fifoEmpty = (fillCount == '0);
   assign inRange   = (x <= X_LAST) && (y <= Y_LAST);
   assign in_ready  = !fifoFull && !reset;
   assign accept    = plot && in_ready && inRange;
   assign pop       = fb_we && fb_ready;
   assign lastPixel = (x == X_LAST) && (y == Y_LAST);

   // Full-width product: in-range coordinates always fit in ADDR_W bits.
   assign pixAddr = ADDR_W'(y) * ADDR_W'(X_MAX + 1) + ADDR_W'(x);

   // Head is read combinationally; outputs read as zero while nothing is queued.
   assign headEntry = fifoMem[rdPtr];
   assign fb_we     = !fifoEmpty;
   assign fb_addr   = fifoEmpty ? '0 : headEntry[ENTRY_W-1:COLOR_W];
   assign fb_data   = fifoEmpty ? '0 : headEntry[COLOR_W-1:0];

   always_comb begin
      nextX = x + 8'd1;
      nextY = y;
      if (x == X_LAST) begin
         nextX = 8'd0;
         nextY = (y == Y_LAST) ? 8'd0 : y + 8'd1;
      end
   end

   // Storage carries no reset; accept is already blocked while reset is high.
   always_ff @(posedge clk) begin
      if (accept) begin
         fifoMem[wrPtr] <= {pixAddr, color};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr      <= '0;
         rdPtr      <= '0;
         fillCount  <= '0;
         expX       <= 8'd0;
         expY       <= 8'd0;
         frame_done <= 1'b0;
         frame_cnt  <= 8'd0;
         order_err  <= 1'b0;
         range_err  <= 1'b0;
         drop_cnt   <= 8'd0;
      end else begin
         if (accept) begin
            wrPtr <= wrPtr + PTR_W'(1);
         end
         if (pop) begin
            rdPtr <= rdPtr + PTR_W'(1);
         end
         case ({accept, pop})
            2'b10:   fillCount <= fillCount + (PTR_W+1)'(1);
            2'b01:   fillCount <= fillCount - (PTR_W+1)'(1);
            default: fillCount <= fillCount;
         endcase

         // Expected position always follows the last accepted pixel, right or wrong.
         if (accept) begin
            if ((x != expX) || (y != expY)) begin
               order_err <= 1'b1;
            end
            expX <= nextX;
            expY <= nextY;
         end

         frame_done <= accept && lastPixel;
         if (accept && lastPixel) begin
            frame_cnt <= frame_cnt + 8'd1;
         end

         if (plot && !inRange) begin
            range_err <= 1'b1;
         end
         if (plot && fifoFull && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_plot_frame_receiver.sv
// Directed plus randomized bench for plot_frame_receiver; the reference model works on
// linear pixel indices and a queue of pending writes.
module tb_plot_frame_receiver;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] x;
   logic [7:0] y;
   logic [2:0] color;
   logic       plot;
   logic       fbReady;
   logic       in_ready;
   logic [14:0] fb_addr;
   logic [2:0] fb_data;
   logic       fb_we;
   logic       frame_done;
   logic [7:0] frame_cnt;
   logic       order_err;
   logic       range_err;
   logic [7:0] drop_cnt;

   always #5 clk = ~clk;

   plot_frame_receiver dut (
      .clk(clk), .reset(reset), .x(x), .y(y), .color(color), .plot(plot),
      .in_ready(in_ready), .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we),
      .fb_ready(fbReady), .frame_done(frame_done), .frame_cnt(frame_cnt),
      .order_err(order_err), .range_err(range_err), .drop_cnt(drop_cnt)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   int qa[$];
   int qc[$];
   int ex = 0, ey = 0;
   int frameCntM = 0, dropM = 0, orderM = 0, rangeM = 0, frameDoneM = 0;
   int writes = 0, lastAddr = -1, doneSeen = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: check pre-edge outputs, advance the model, check post-edge outputs.
   task automatic cycle();
      int sz, idx, nxt;
      bit inr, acc;
      #1;
      sz = qa.size();
      chk("in_ready", 32'(in_ready), 32'(reset == 1'b0 && sz < 4));
      chk("fb_we", 32'(fb_we), 32'(sz > 0));
      if (sz > 0) begin
         chk("fb_addr", 32'(fb_addr), 32'(qa[0]));
         chk("fb_data", 32'(fb_data), 32'(qc[0]));
      end
      inr = (int'(x) <= 159) && (int'(y) <= 119);
      acc = plot && !reset && (sz < 4) && inr;
      if (reset) begin
         qa.delete(); qc.delete();
         ex = 0; ey = 0;
         frameCntM = 0; dropM = 0; orderM = 0; rangeM = 0; frameDoneM = 0;
      end else begin
         frameDoneM = 0;
         if (sz > 0 && fbReady) begin
            lastAddr = qa.pop_front();
            void'(qc.pop_front());
            writes++;
         end
         if (plot && !inr) rangeM = 1;
         if (plot && sz >= 4 && dropM < 255) dropM++;
         if (acc) begin
            idx = int'(y) * 160 + int'(x);
            qa.push_back(idx);
            qc.push_back(int'(color));
            if (int'(x) != ex || int'(y) != ey) orderM = 1;
            nxt = (idx + 1) % 19200;
            ex = nxt % 160;
            ey = nxt / 160;
            if (idx == 19199) begin
               frameDoneM = 1;
               frameCntM = (frameCntM + 1) % 256;
            end
         end
      end
      @(posedge clk);
      #1;
      if (frame_done === 1'b1) doneSeen++;
      chk("frame_done", 32'(frame_done), 32'(frameDoneM));
      chk("frame_cnt", 32'(frame_cnt), 32'(frameCntM));
      chk("order_err", 32'(order_err), 32'(orderM));
      chk("range_err", 32'(range_err), 32'(rangeM));
      chk("drop_cnt", 32'(drop_cnt), 32'(dropM));
   endtask

   task automatic idle(input int n);
      plot = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic px(input int px_x, input int px_y, input int px_c);
      x = 8'(px_x); y = 8'(px_y); color = 3'(px_c); plot = 1'b1;
      cycle();
      plot = 1'b0;
   endtask

   task automatic doReset();
      reset = 1'b1; plot = 1'b0;
      cycle(); cycle();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; plot = 1'b0; x = 8'd0; y = 8'd0; color = 3'd0; fbReady = 1'b1;
      @(posedge clk);
      #1;

      // T1: reset state, single pixel
      doReset();
      chk("rst_fb_we", 32'(fb_we), 32'd0);
      chk("rst_fb_addr", 32'(fb_addr), 32'd0);
      chk("rst_fb_data", 32'(fb_data), 32'd0);
      px(0, 0, 5);
      chk("t1_fb_we", 32'(fb_we), 32'd1);
      chk("t1_fb_addr", 32'(fb_addr), 32'd0);
      chk("t1_fb_data", 32'(fb_data), 32'd5);
      idle(2);
      chk("t1_fb_we_after", 32'(fb_we), 32'd0);

      // T2: full in-order raster, one plot every other cycle
      doReset();
      writes = 0; doneSeen = 0;
      for (int r = 0; r < 120; r++) begin
         for (int c = 0; c < 160; c++) begin
            px(c, r, int'($urandom_range(0, 7)));
            idle(1);
         end
      end
      idle(3);
      chk("t2_writes", 32'(writes), 32'd19200);
      chk("t2_last_addr", 32'(lastAddr), 32'd19199);
      chk("t2_done_pulses", 32'(doneSeen), 32'd1);
      chk("t2_frame_cnt", 32'(frame_cnt), 32'd1);
      chk("t2_order_err", 32'(order_err), 32'd0);

      // T3: stalled RAM, six back-to-back plots
      doReset();
      fbReady = 1'b0;
      for (int c = 0; c < 6; c++) px(c, 0, c);
      chk("t3_in_ready", 32'(in_ready), 32'd0);
      chk("t3_drop_cnt", 32'(drop_cnt), 32'd2);
      fbReady = 1'b1;
      writes = 0;
      idle(6);
      chk("t3_writes", 32'(writes), 32'd4);
      chk("t3_last_addr", 32'(lastAddr), 32'd3);

      // T4: order error is sticky
      doReset();
      px(0, 0, 1); idle(1);
      px(5, 0, 2); idle(1);
      chk("t4_order_err", 32'(order_err), 32'd1);
      px(6, 0, 3); idle(1);
      chk("t4_order_sticky", 32'(order_err), 32'd1);

      // T5: out-of-range plots
      doReset();
      px(160, 3, 1); idle(1);
      chk("t5_range_err", 32'(range_err), 32'd1);
      chk("t5_no_we", 32'(fb_we), 32'd0);
      px(0, 120, 1); idle(1);
      chk("t5_no_we_y", 32'(fb_we), 32'd0);

      // T6: reset with entries queued
      doReset();
      fbReady = 1'b0;
      px(0, 0, 1); px(1, 0, 2); px(2, 0, 3);
      chk("t6_queued", 32'(fb_we), 32'd1);
      doReset();
      chk("t6_fb_we", 32'(fb_we), 32'd0);
      chk("t6_fb_addr", 32'(fb_addr), 32'd0);
      chk("t6_drop_cnt", 32'(drop_cnt), 32'd0);
      fbReady = 1'b1;
      px(0, 0, 6);
      chk("t6_replot_addr", 32'(fb_addr), 32'd0);
      chk("t6_replot_data", 32'(fb_data), 32'd6);
      idle(2);

      // Randomized traffic: stalls, bursts, skips and occasional out-of-range plots
      doReset();
      for (int i = 0; i < 3000; i++) begin
         fbReady = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1) begin
            if ($urandom_range(0, 3) != 0) begin
               x = 8'(ex); y = 8'(ey);
            end else begin
               x = 8'($urandom_range(0, 165));
               y = 8'($urandom_range(0, 122));
            end
            color = 3'($urandom_range(0, 7));
            plot = 1'b1;
         end else begin
            plot = 1'b0;
         end
         cycle();
      end
      fbReady = 1'b1;
      idle(6);
      chk("rand_drained", 32'(fb_we), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
